regfile_mp: RTL

Parametrised multi-port integer register file for the CPU core, successor to the single-write, dual-read file. Supports configurable width, depth, read-port and write-port count, and an optional hardwired zero register. Reads are registered with write-through bypass. A per-register busy scoreboard is built in so decode can stall on pending writebacks.

---
 rtl/regfile_mp_pkg.sv | 12 +
 rtl/regfile_mp_if.sv | 32 +++
 rtl/regfile_mp_sb.sv | 34 +++
 rtl/regfile_mp.sv | 83 ++++++++
 4 files changed

// File: rtl/regfile_mp_pkg.sv
// Shared CPU register-file constants and types.
// Module parameters default to these values so the core top needs no overrides.
package regfile_mp_pkg;
  localparam int XLEN     = 32;
  localparam int NREGS    = 32;
  localparam int AW       = $clog2(NREGS);
  localparam int NRD      = 2;
  localparam int NWR      = 2;
  localparam int ZERO_IDX = 0;

  typedef logic [AW-1:0] reg_addr_t;
endpackage

// File: rtl/regfile_mp_if.sv
// Bus between decode/writeback (master) and the multi-port register file (slave).
// Read handshake: rd_en[j] is a one-cycle request with no backpressure; the file always
// accepts it and presents rd_data[j]/rd_busy[j] after the next posedge, holding them until the next request.
interface regfile_mp_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  parameter int NWR   = 2
);
  localparam int AW = $clog2(NREGS);

  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic [NRD-1:0]      rd_en;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic                sb_set_en;
  logic [AW-1:0]       sb_set_addr;
  logic [NREGS-1:0]    sb_busy;

  modport master (
    output wr_en, wr_addr, wr_data, rd_en, rd_addr, sb_set_en, sb_set_addr,
    input  rd_data, rd_busy, sb_busy
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_en, rd_addr, sb_set_en, sb_set_addr,
    output rd_data, rd_busy, sb_busy
  );
endinterface

// File: rtl/regfile_mp_sb.sv
// Per-register busy scoreboard: issue sets a bit, accepted writeback clears it.
// busy_nxt is exported so registered read ports can capture the post-update flag.
module regfile_sb
  import regfile_mp_pkg::*;
#(
  parameter int NREGS    = regfile_mp_pkg::NREGS,
  parameter int NWR      = regfile_mp_pkg::NWR,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          set_en,
  input  logic [$clog2(NREGS)-1:0]      set_addr,
  input  logic [NWR-1:0]                clr_en,
  input  logic [NWR*$clog2(NREGS)-1:0]  clr_addr,
  output logic [NREGS-1:0]              busy,
  output logic [NREGS-1:0]              busy_nxt
);
  localparam int SAW = $clog2(NREGS);

  // Set is applied after all clears: a newly issued producer outranks the retiring one.
  always_comb begin
    busy_nxt = busy;
    for (int i = 0; i < NWR; i++)
      if (clr_en[i]) busy_nxt[clr_addr[i*SAW +: SAW]] = 1'b0;
    if (set_en) busy_nxt[set_addr] = 1'b1;
    if (ZERO_REG) busy_nxt[ZERO_IDX] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) busy <= '0;
    else       busy <= busy_nxt;
  end
endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with write-first registered reads and a busy scoreboard.
// All outputs come straight from flops; reads see the same edge's writes via regs_nxt.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int XLEN     = regfile_mp_pkg::XLEN,
  parameter int NREGS    = regfile_mp_pkg::NREGS,
  parameter int NRD      = regfile_mp_pkg::NRD,
  parameter int NWR      = regfile_mp_pkg::NWR,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  regfile_mp_if.slave bus
);
  localparam int LAW = $clog2(NREGS);

  logic [XLEN-1:0]  regs      [NREGS];
  logic [XLEN-1:0]  regs_nxt  [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;
  logic [NWR-1:0]   wr_acc;
  logic [XLEN-1:0]  rd_sel_data [NRD];
  logic [NRD-1:0]   rd_sel_busy;
  logic [XLEN-1:0]  rd_data_q   [NRD];
  logic [NRD-1:0]   rd_busy_q;

  // Writes to the hardwired zero register are dropped before they reach storage or the scoreboard.
  always_comb begin
    wr_acc = bus.wr_en;
    if (ZERO_REG)
      for (int i = 0; i < NWR; i++)
        if (bus.wr_addr[i*LAW +: LAW] == LAW'(ZERO_IDX)) wr_acc[i] = 1'b0;
  end

  // Ascending lane order makes the highest-index lane win an address collision.
  always_comb begin
    regs_nxt = regs;
    for (int i = 0; i < NWR; i++)
      if (wr_acc[i]) regs_nxt[bus.wr_addr[i*LAW +: LAW]] = bus.wr_data[i*XLEN +: XLEN];
  end

  regfile_sb #(
    .NREGS    (NREGS),
    .NWR      (NWR),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk      (clk),
    .reset    (reset),
    .set_en   (bus.sb_set_en),
    .set_addr (bus.sb_set_addr),
    .clr_en   (wr_acc),
    .clr_addr (bus.wr_addr),
    .busy     (busy),
    .busy_nxt (busy_nxt)
  );

  for (genvar j = 0; j < NRD; j++) begin : g_rd
    logic [LAW-1:0] addr;
    assign addr           = bus.rd_addr[j*LAW +: LAW];
    assign rd_sel_data[j] = regs_nxt[addr];
    assign rd_sel_busy[j] = busy_nxt[addr];
    assign bus.rd_data[j*XLEN +: XLEN] = rd_data_q[j];
  end

  assign bus.rd_busy = rd_busy_q;
  assign bus.sb_busy = busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NREGS; r++) regs[r] <= '0;
      for (int j = 0; j < NRD; j++) rd_data_q[j] <= '0;
      rd_busy_q <= '0;
    end else begin
      regs <= regs_nxt;
      for (int j = 0; j < NRD; j++)
        if (bus.rd_en[j]) begin
          rd_data_q[j] <= rd_sel_data[j];
          rd_busy_q[j] <= rd_sel_busy[j];
        end
    end
  end
endmodule
